// File: rtl/prog_seq_pkg.sv
// Shared types for the programmable sequencer: FSM states and the
// per-cycle action chosen while running.
package prog_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Exactly one of these is applied per RUN cycle.
  typedef enum logic [2:0] {
    ACT_HALT   = 3'd0,
    ACT_STALL  = 3'd1,
    ACT_RET    = 3'd2,
    ACT_CALL   = 3'd3,
    ACT_BRANCH = 3'd4,
    ACT_INC    = 3'd5
  } run_act_t;

  // Resolve simultaneous requests: Halt > Stall > Ret > Call > BranchEn > increment.
  function automatic run_act_t pick_action(input logic halt, input logic stall,
                                           input logic ret, input logic call,
                                           input logic branch);
    if (halt)        return ACT_HALT;
    else if (stall)  return ACT_STALL;
    else if (ret)    return ACT_RET;
    else if (call)   return ACT_CALL;
    else if (branch) return ACT_BRANCH;
    else             return ACT_INC;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address stack: D entries of A bits, LIFO, with a synchronous
// clear used when a new run is armed.
module ret_stack #(
  parameter int A = 10,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [A-1:0] push_data,
  output logic [A-1:0] top,
  output logic         full,
  output logic         empty
);

  // Pointer counts occupied entries, so it must reach D itself.
  localparam int PW = $clog2(D + 1);
  localparam int IW = (D > 1) ? $clog2(D) : 1;

  logic [PW-1:0] sp;
  logic [PW-1:0] sp_dec;
  logic [A-1:0]  mem [D];

  assign sp_dec = sp - PW'(1);
  assign full   = (sp == PW'(D));
  assign empty  = (sp == '0);
  assign top    = empty ? '0 : mem[IW'(sp_dec)];

  // Stack pointer: reset/clear empties the stack, push has priority over pop.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always updated with non-blocking assignments
    // so every flop samples pre-edge values regardless of statement order.
    if (Reset || clr)       sp <= '0;
    else if (push && !full) sp <= sp + PW'(1);
    else if (pop && !empty) sp <= sp_dec;
  end

  // Entry storage: written on push only.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; the pointer alone
    // defines which entries are valid, and stale data is never read.
    if (push && !full && !Reset && !clr) mem[IW'(sp)] <= push_data;
  end

endmodule

// File: rtl/prog_seq.sv
// Programmable sequencer: program counter with absolute/relative branch,
// call/return through a hardware return stack, and an IDLE/ARMED/RUN/DONE
// control FSM started by the falling edge of Start.
module prog_seq
  import prog_seq_pkg::*;
#(
  parameter int A = 10,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Stall,
  input  logic         Halt,
  input  logic         BranchEn,
  input  logic         BranchRel,
  input  logic         Call,
  input  logic         Ret,
  input  logic [A-1:0] Target,
  output logic [A-1:0] ProgCtr,
  output logic         Running,
  output logic         Done,
  output logic         Fault
);

  seq_state_t   state;
  logic [A-1:0] pc;
  logic [A-1:0] pc_inc;
  logic         fault;
  run_act_t     act;

  logic         stk_clr;
  logic         stk_push;
  logic         stk_pop;
  logic [A-1:0] stk_top;
  logic         stk_full;
  logic         stk_empty;

  assign act    = pick_action(Halt, Stall, Ret, Call, BranchEn);
  assign pc_inc = pc + A'(1);

  // Stack control is only active in RUN; arming from IDLE/DONE clears it.
  assign stk_clr  = ((state == IDLE) || (state == DONE)) && Start;
  assign stk_push = (state == RUN) && (act == ACT_CALL) && !stk_full;
  assign stk_pop  = (state == RUN) && (act == ACT_RET) && !stk_empty;

  ret_stack #(
    .A(A),
    .D(D)
  ) u_ret_stack (
    .clk      (clk),
    .Reset    (Reset),
    .clr      (stk_clr),
    .push     (stk_push),
    .pop      (stk_pop),
    .push_data(pc_inc),
    .top      (stk_top),
    .full     (stk_full),
    .empty    (stk_empty)
  );

  // Control FSM together with program counter and sticky fault flag.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= IDLE;
      pc    <= '0;
      fault <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            state <= ARMED;
            pc    <= '0;
            fault <= 1'b0;
          end
        end
        ARMED: begin
          if (!Start) state <= RUN;
        end
        RUN: begin
          case (act)
            ACT_HALT:  state <= DONE;
            ACT_STALL: ;
            ACT_RET: begin
              if (stk_empty) begin
                fault <= 1'b1;
                state <= DONE;
              end else begin
                pc <= stk_top;
              end
            end
            ACT_CALL: begin
              if (stk_full) begin
                fault <= 1'b1;
                state <= DONE;
              end else begin
                pc <= Target;
              end
            end
            ACT_BRANCH: pc <= BranchRel ? (pc + Target) : Target;
            default:    pc <= pc_inc;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only; no input reaches them combinationally.
  assign ProgCtr = pc;
  assign Running = (state == RUN);
  assign Done    = (state == DONE);
  assign Fault   = fault;

endmodule

// File: tb/tb_prog_seq.sv
// Self-checking bench for prog_seq: directed scenarios plus randomized
// stimulus, all compared against a queue-based behavioural model.
module tb_prog_seq;

  localparam int A   = 10;
  localparam int D   = 4;
  localparam int MOD = 1 << A;

  logic         clk;
  logic         Reset;
  logic         Start;
  logic         Stall;
  logic         Halt;
  logic         BranchEn;
  logic         BranchRel;
  logic         Call;
  logic         Ret;
  logic [A-1:0] Target;
  logic [A-1:0] ProgCtr;
  logic         Running;
  logic         Done;
  logic         Fault;

  prog_seq #(
    .A(A),
    .D(D)
  ) dut (
    .clk      (clk),
    .Reset    (Reset),
    .Start    (Start),
    .Stall    (Stall),
    .Halt     (Halt),
    .BranchEn (BranchEn),
    .BranchRel(BranchRel),
    .Call     (Call),
    .Ret      (Ret),
    .Target   (Target),
    .ProgCtr  (ProgCtr),
    .Running  (Running),
    .Done     (Done),
    .Fault    (Fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference model.
  typedef enum int {P_IDLE, P_ARMED, P_RUN, P_DONE} phase_t;
  phase_t      m_phase;
  int unsigned m_pc;
  bit          m_fault;
  int unsigned m_stk[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step();
    if (Reset) begin
      m_phase = P_IDLE;
      m_pc    = 0;
      m_fault = 0;
      m_stk.delete();
    end else begin
      case (m_phase)
        P_IDLE, P_DONE: if (Start) begin
          m_phase = P_ARMED;
          m_pc    = 0;
          m_fault = 0;
          m_stk.delete();
        end
        P_ARMED: if (!Start) m_phase = P_RUN;
        P_RUN: begin
          if (Halt) m_phase = P_DONE;
          else if (Stall) begin
          end else if (Ret) begin
            if (m_stk.size() == 0) begin
              m_fault = 1;
              m_phase = P_DONE;
            end else m_pc = m_stk.pop_back();
          end else if (Call) begin
            if (m_stk.size() == D) begin
              m_fault = 1;
              m_phase = P_DONE;
            end else begin
              m_stk.push_back((m_pc + 1) % MOD);
              m_pc = Target;
            end
          end else if (BranchEn) begin
            m_pc = BranchRel ? (m_pc + Target) % MOD : Target;
          end else m_pc = (m_pc + 1) % MOD;
        end
        default: m_phase = P_IDLE;
      endcase
    end
  endfunction

  // One clock: advance the model with the current inputs, then compare.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("pc",      ProgCtr, m_pc);
    check("running", Running, (m_phase == P_RUN) ? 1 : 0);
    check("done",    Done,    (m_phase == P_DONE) ? 1 : 0);
    check("fault",   Fault,   m_fault);
  endtask

  task automatic quiet();
    Start = 0; Stall = 0; Halt = 0; BranchEn = 0;
    BranchRel = 0; Call = 0; Ret = 0; Target = '0;
  endtask

  // Arm (Start high for two cycles) and enter RUN at PC 0.
  task automatic arm_and_run();
    quiet();
    Start = 1; tick(); tick();
    Start = 0; tick();
  endtask

  initial begin
    m_phase = P_IDLE; m_pc = 0; m_fault = 0;
    quiet();
    Reset = 1;
    tick(); tick();
    check("rst_pc", ProgCtr, 0);
    check("rst_running", Running, 0);
    Reset = 0;

    // Arming and running.
    Start = 1; tick(); tick();
    check("armed_not_running", Running, 0);
    Start = 0; tick();
    check("run_first", Running, 1);
    check("run_pc0", ProgCtr, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("run_inc", ProgCtr, i);
    end

    // Wrap and relative branch.
    BranchEn = 1; Target = 10'd1021; tick();
    BranchEn = 0; tick(); tick();
    check("pc_1023", ProgCtr, 1023);
    tick();
    check("wrap_0", ProgCtr, 0);
    check("wrap_nofault", Fault, 0);
    BranchEn = 1; Target = 10'd5; tick();
    BranchRel = 1; Target = 10'h3FE; tick();
    check("rel_minus2", ProgCtr, 3);
    quiet();

    // Call/return.
    BranchEn = 1; Target = 10'd4; tick();
    BranchEn = 0; Call = 1; Target = 10'd100; tick();
    check("call_pc", ProgCtr, 100);
    Call = 0; tick(); tick();
    check("callee_inc", ProgCtr, 102);
    Ret = 1; tick();
    check("ret_pc", ProgCtr, 5);
    check("ret_nofault", Fault, 0);
    Ret = 0;

    // Overflow: fifth nested call faults.
    for (int i = 0; i < 5; i++) begin
      Call = 1; Target = 10'(200 + 10 * i); tick();
    end
    check("ovf_fault", Fault, 1);
    check("ovf_pc", ProgCtr, 230);
    check("ovf_done", Done, 1);
    quiet(); tick();
    check("ovf_done_hold", Done, 1);

    // Underflow: Ret on empty stack in a fresh run.
    arm_and_run();
    check("rearm_clears_fault", Fault, 0);
    Ret = 1; tick();
    check("unf_fault", Fault, 1);
    check("unf_pc", ProgCtr, 0);
    check("unf_done", Done, 1);

    // Priority: Stall beats BranchEn; Halt beats Call.
    arm_and_run();
    tick(); tick();
    Stall = 1; BranchEn = 1; Target = 10'd77; tick();
    check("stall_hold", ProgCtr, 2);
    quiet(); tick();
    Halt = 1; Call = 1; Target = 10'd50; tick();
    check("halt_done", Done, 1);
    check("halt_pc", ProgCtr, 3);
    check("halt_nofault", Fault, 0);
    quiet(); Ret = 1; tick();
    check("done_ignores_ret", Fault, 0);

    // Reset mid-run with two stacked returns.
    arm_and_run();
    Call = 1; Target = 10'd10; tick();
    Target = 10'd35; tick();
    Call = 0; tick(); tick();
    check("pre_reset_pc", ProgCtr, 37);
    Reset = 1; tick();
    check("mid_rst_pc", ProgCtr, 0);
    check("mid_rst_running", Running, 0);
    check("mid_rst_done", Done, 0);
    check("mid_rst_fault", Fault, 0);
    Reset = 0; quiet(); tick();
    check("post_rst_idle", Running, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      Reset     = ($urandom_range(0, 299) == 0);
      Start     = ($urandom_range(0, 7) == 0);
      Halt      = ($urandom_range(0, 39) == 0);
      Stall     = ($urandom_range(0, 5) == 0);
      Ret       = ($urandom_range(0, 5) == 0);
      Call      = ($urandom_range(0, 4) == 0);
      BranchEn  = ($urandom_range(0, 5) == 0);
      BranchRel = $urandom_range(0, 1) == 1;
      Target    = A'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
